reg_file_param: RTL and testbench

Parametrised, clocked successor to the 16x16 behavioural register file: a 2^ADDR_W-entry by DATA_W-bit register file with two registered read ports, one write port and optional write-to-read bypass. It adds an optional hard-wired zero register, a multi-cycle background scrub engine, and a registered debug window. It sits between the datapath ALU (A/B operands, C result) and the board debug display mux.

---
 rtl/reg_file_param.sv | 205 ++++++++++++++++++++
 tb/tb_reg_file_param.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Clocked 2^ADDR_W x DATA_W register file sitting between the datapath ALU
// (A/B operand reads, C result write) and the board debug display mux.
// It has two registered read ports, one write port, an optional write-first
// bypass, an optional hard-wired zero entry, a sequential scrub engine that
// zeroes every entry one per cycle, and a registered two-entry debug window.
//
// Parameters
//   DATA_W  : entry width in bits
//   ADDR_W  : address width, DEPTH = 2^ADDR_W
//   ZERO_R0 : 1 -> entry 0 always reads 0 and writes to it are discarded
//   BYPASS  : 1 -> a read of the entry written at the same edge sees new data
//
// Ports
//   clk     : system clock, rising-edge active
//   clear   : synchronous active-high reset, overrides everything
//   a_addr  : read port A address      a_data : registered read data A
//   b_addr  : read port B address      b_data : registered read data B
//   c_addr  : write address            c_data : write data
//   load    : write enable (ignored while scrubbing)
//   scrub   : start a full zeroing sequence (sampled in IDLE only)
//   busy    : high while the scrub sequence is running
//   m_state : debug window base index
//   m_data  : registered {mem[m_state], mem[m_state+1 mod DEPTH]}
// ---------------------------------------------------------------------------
module reg_file_param #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic [ADDR_W-1:0]     a_addr,
   input  logic [ADDR_W-1:0]     b_addr,
   input  logic [ADDR_W-1:0]     c_addr,
   input  logic [DATA_W-1:0]     c_data,
   input  logic                  load,
   input  logic                  scrub,
   output logic                  busy,
   output logic [DATA_W-1:0]     a_data,
   output logic [DATA_W-1:0]     b_data,
   input  logic [ADDR_W-1:0]     m_state,
   output logic [2*DATA_W-1:0]   m_data
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SCRUB = 1'b1;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   logic [DATA_W-1:0]   mem_r [DEPTH];
   logic [0:0]          state_r;
   logic [ADDR_W-1:0]   idx_r;
   logic                busy_r;
   logic [DATA_W-1:0]   a_data_r;
   logic [DATA_W-1:0]   b_data_r;
   logic [2*DATA_W-1:0] m_data_r;

   logic                wr_req_s;
   logic                wr_en_s;
   logic [ADDR_W-1:0]   wr_addr_s;
   logic [DATA_W-1:0]   wr_data_s;
   logic [ADDR_W-1:0]   m_next_addr_s;
   logic [DATA_W-1:0]   a_next_s;
   logic [DATA_W-1:0]   b_next_s;
   logic [2*DATA_W-1:0] m_next_s;

   // Value a read port captures for addr: zero entry first, then the write
   // committing at this edge (write-first bypass), otherwise stored contents.
   function automatic logic [DATA_W-1:0] port_value(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored,
      input logic              we,
      input logic [ADDR_W-1:0] wa,
      input logic [DATA_W-1:0] wd
   );
      logic [DATA_W-1:0] val;
      if ((ZERO_R0 != 0) && (addr == ADDR_ZERO)) begin
         val = DATA_ZERO;
      end else if ((BYPASS != 0) && we && (wa == addr)) begin
         val = wd;
      end else begin
         val = stored;
      end
      return val;
   endfunction

   // Select the single write source: host port in IDLE, zero at idx while scrubbing.
   always_comb begin
      wr_req_s  = 1'b0;
      wr_addr_s = c_addr;
      wr_data_s = c_data;
      case (state_r)
         ST_IDLE: begin
            wr_req_s  = load;
            wr_addr_s = c_addr;
            wr_data_s = c_data;
         end
         ST_SCRUB: begin
            wr_req_s  = 1'b1;
            wr_addr_s = idx_r;
            wr_data_s = DATA_ZERO;
         end
         default: begin
            wr_req_s  = 1'b0;
            wr_addr_s = c_addr;
            wr_data_s = c_data;
         end
      endcase
   end

   // Writes to the hard-wired zero entry never commit.
   assign wr_en_s = wr_req_s && !((ZERO_R0 != 0) && (wr_addr_s == ADDR_ZERO));

   // Second debug entry wraps naturally in ADDR_W-bit arithmetic.
   assign m_next_addr_s = m_state + ADDR_W'(1);

   // Next values for the read ports and the debug window.
   always_comb begin
      a_next_s = port_value(a_addr, mem_r[a_addr], wr_en_s, wr_addr_s, wr_data_s);
      b_next_s = port_value(b_addr, mem_r[b_addr], wr_en_s, wr_addr_s, wr_data_s);
      m_next_s = {port_value(m_state, mem_r[m_state], wr_en_s, wr_addr_s, wr_data_s),
                  port_value(m_next_addr_s, mem_r[m_next_addr_s], wr_en_s,
                             wr_addr_s, wr_data_s)};
   end

   // Storage array: clear zeroes every entry, otherwise commit the selected write.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= DATA_ZERO;
         end
      end else if (wr_en_s) begin
         mem_r[wr_addr_s] <= wr_data_s;
      end else begin
         mem_r[wr_addr_s] <= mem_r[wr_addr_s];
      end
   end

   // Registered read ports and debug window.
   always_ff @(posedge clk) begin
      if (clear) begin
         a_data_r <= DATA_ZERO;
         b_data_r <= DATA_ZERO;
         m_data_r <= {DATA_ZERO, DATA_ZERO};
      end else begin
         a_data_r <= a_next_s;
         b_data_r <= b_next_s;
         m_data_r <= m_next_s;
      end
   end

   // Scrub FSM: one zero write per cycle, exits on the edge that zeroes the
   // last entry; idx holds there instead of wrapping into a second pass.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_r <= ST_IDLE;
         idx_r   <= ADDR_ZERO;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (scrub) begin
                  state_r <= ST_SCRUB;
                  idx_r   <= ADDR_ZERO;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  idx_r   <= idx_r;
                  busy_r  <= 1'b0;
               end
            end
            ST_SCRUB: begin
               if (idx_r == ADDR_LAST) begin
                  state_r <= ST_IDLE;
                  idx_r   <= idx_r;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_SCRUB;
                  idx_r   <= idx_r + ADDR_W'(1);
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               idx_r   <= ADDR_ZERO;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_r;
   assign a_data = a_data_r;
   assign b_data = b_data_r;
   assign m_data = m_data_r;

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//
// Directed bench for reg_file_param. Three instances share one stimulus:
//   u_byp  : ZERO_R0=0, BYPASS=1 (default configuration)
//   u_nobp : ZERO_R0=0, BYPASS=0
//   u_zero : ZERO_R0=1, BYPASS=1
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

   logic        clk;
   logic        clear;
   logic [3:0]  a_addr;
   logic [3:0]  b_addr;
   logic [3:0]  c_addr;
   logic [15:0] c_data;
   logic        load;
   logic        scrub;
   logic [3:0]  m_state;

   logic        busy0, busy1, busy2;
   logic [15:0] a0, a1, a2;
   logic [15:0] b0, b1, b2;
   logic [31:0] m0, m1, m2;

   int checks;
   int errors;

   reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .BYPASS(1)) u_byp (
      .clk(clk), .clear(clear), .a_addr(a_addr), .b_addr(b_addr),
      .c_addr(c_addr), .c_data(c_data), .load(load), .scrub(scrub),
      .busy(busy0), .a_data(a0), .b_data(b0), .m_state(m_state), .m_data(m0)
   );

   reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .BYPASS(0)) u_nobp (
      .clk(clk), .clear(clear), .a_addr(a_addr), .b_addr(b_addr),
      .c_addr(c_addr), .c_data(c_data), .load(load), .scrub(scrub),
      .busy(busy1), .a_data(a1), .b_data(b1), .m_state(m_state), .m_data(m1)
   );

   reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .BYPASS(1)) u_zero (
      .clk(clk), .clear(clear), .a_addr(a_addr), .b_addr(b_addr),
      .c_addr(c_addr), .c_data(c_data), .load(load), .scrub(scrub),
      .busy(busy2), .a_data(a2), .b_data(b2), .m_state(m_state), .m_data(m2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [15:0] base);
      for (int i = 0; i < 16; i++) begin
         load   = 1'b1;
         c_addr = 4'(i);
         c_data = base + 16'(i);
         tick;
      end
      load = 1'b0;
   endtask

   task automatic test_reset;
      clear = 1'b1;
      tick;
      clear = 1'b0;
      checks++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
         $display("FAIL reset_busy: got %b%b%b expected 000", busy0, busy1, busy2);
         errors++;
      end
      for (int i = 0; i < 16; i++) begin
         a_addr = 4'(i);
         b_addr = 4'(15 - i);
         tick;
         checks++;
         if (a0 !== 16'h0000 || b0 !== 16'h0000) begin
            $display("FAIL reset_read[%0d]: got a=%h b=%h expected 0000", i, a0, b0);
            errors++;
         end
      end
   endtask

   task automatic test_bypass;
      load = 1'b1; c_addr = 4'd5; c_data = 16'hBEEF;
      a_addr = 4'd5; b_addr = 4'd5;
      tick;
      load = 1'b0;
      checks++;
      if (a0 !== 16'hBEEF || b0 !== 16'hBEEF) begin
         $display("FAIL bypass_same_edge: got a=%h b=%h expected beef", a0, b0);
         errors++;
      end
      checks++;
      if (a1 !== 16'h0000 || b1 !== 16'h0000) begin
         $display("FAIL nobypass_same_edge: got a=%h b=%h expected 0000", a1, b1);
         errors++;
      end
      tick;
      checks++;
      if (a1 !== 16'hBEEF || a0 !== 16'hBEEF) begin
         $display("FAIL write_next_cycle: got nobp=%h byp=%h expected beef", a1, a0);
         errors++;
      end
   endtask

   task automatic test_zero_reg;
      load = 1'b1; c_addr = 4'd0; c_data = 16'h1234; a_addr = 4'd0;
      tick;
      load = 1'b0;
      checks++;
      if (a2 !== 16'h0000 || a0 !== 16'h1234) begin
         $display("FAIL zero_r0_bypass: got zero=%h byp=%h expected 0000/1234", a2, a0);
         errors++;
      end
      tick;
      checks++;
      if (a2 !== 16'h0000) begin
         $display("FAIL zero_r0_read: got %h expected 0000", a2);
         errors++;
      end
      load = 1'b1; c_addr = 4'd1; c_data = 16'h1234; a_addr = 4'd1;
      tick;
      load = 1'b0;
      tick;
      checks++;
      if (a2 !== 16'h1234) begin
         $display("FAIL zero_r1_read: got %h expected 1234", a2);
         errors++;
      end
   endtask

   task automatic test_scrub;
      int cnt;
      fill(16'h1000);
      scrub = 1'b1; a_addr = 4'd10;
      tick;
      checks++;
      if (busy0 !== 1'b1 || a0 !== 16'h100A) begin
         $display("FAIL scrub_start: got busy=%b a=%h expected 1/100a", busy0, a0);
         errors++;
      end
      cnt = 1;
      for (int k = 1; k < 40; k++) begin
         if (k == 1) begin
            scrub = 1'b0; load = 1'b1; c_addr = 4'd3; c_data = 16'hAAAA;
            a_addr = 4'd3; b_addr = 4'd10;
         end
         if (k == 2) load = 1'b0;
         if (k == 4) begin scrub = 1'b1; a_addr = 4'd3; end
         if (k == 5) scrub = 1'b0;
         tick;
         if (k == 1) begin
            checks++;
            if (a0 !== 16'h1003 || b0 !== 16'h100A) begin
               $display("FAIL scrub_load_ignored: got a=%h b=%h expected 1003/100a", a0, b0);
               errors++;
            end
         end
         if (k == 4) begin
            checks++;
            if (a0 !== 16'h0000 || a1 !== 16'h1003) begin
               $display("FAIL scrub_bypass: got byp=%h nobp=%h expected 0000/1003", a0, a1);
               errors++;
            end
         end
         if (busy0 === 1'b1) cnt++;
         else break;
      end
      checks++;
      if (cnt != 16) begin
         $display("FAIL scrub_busy_len: got %0d expected 16", cnt);
         errors++;
      end
      for (int i = 0; i < 16; i++) begin
         a_addr = 4'(i);
         b_addr = 4'(i);
         tick;
         checks++;
         if (a0 !== 16'h0000 || b1 !== 16'h0000 || busy0 !== 1'b0) begin
            $display("FAIL scrub_zeroed[%0d]: got byp=%h nobp=%h busy=%b expected 0000/0000/0",
                     i, a0, b1, busy0);
            errors++;
         end
      end
   endtask

   task automatic test_clear_mid;
      logic seen_busy;
      fill(16'h2000);
      scrub = 1'b1;
      tick;
      scrub = 1'b0;
      for (int j = 1; j <= 5; j++) tick;
      checks++;
      if (busy0 !== 1'b1) begin
         $display("FAIL clear_mid_busy6: got %b expected 1", busy0);
         errors++;
      end
      clear = 1'b1;
      tick;
      clear = 1'b0;
      checks++;
      if (busy0 !== 1'b0 || a0 !== 16'h0000) begin
         $display("FAIL clear_mid_edge: got busy=%b a=%h expected 0/0000", busy0, a0);
         errors++;
      end
      seen_busy = 1'b0;
      for (int j = 0; j < 20; j++) begin
         tick;
         if (busy0 !== 1'b0 || busy1 !== 1'b0) seen_busy = 1'b1;
      end
      checks++;
      if (seen_busy !== 1'b0) begin
         $display("FAIL clear_mid_resume: got busy seen=%b expected 0", seen_busy);
         errors++;
      end
      for (int i = 0; i < 16; i++) begin
         a_addr = 4'(i);
         tick;
         checks++;
         if (a0 !== 16'h0000) begin
            $display("FAIL clear_mid_zero[%0d]: got %h expected 0000", i, a0);
            errors++;
         end
      end
   endtask

   task automatic test_debug;
      load = 1'b1; c_addr = 4'd15; c_data = 16'h00FF;
      tick;
      c_addr = 4'd0; c_data = 16'hFF00;
      tick;
      load = 1'b0; m_state = 4'd15;
      tick;
      checks++;
      if (m0 !== 32'h00FFFF00) begin
         $display("FAIL debug_wrap: got %h expected 00ffff00", m0);
         errors++;
      end
      checks++;
      if (m2 !== 32'h00FF0000) begin
         $display("FAIL debug_wrap_zero_r0: got %h expected 00ff0000", m2);
         errors++;
      end
      m_state = 4'd0;
      tick;
      checks++;
      if (m0 !== 32'hFF000000) begin
         $display("FAIL debug_base0: got %h expected ff000000", m0);
         errors++;
      end
      load = 1'b1; c_addr = 4'd7; c_data = 16'h1357; m_state = 4'd6;
      tick;
      load = 1'b0;
      checks++;
      if (m0 !== 32'h00001357 || m1 !== 32'h00000000) begin
         $display("FAIL debug_bypass: got byp=%h nobp=%h expected 00001357/00000000", m0, m1);
         errors++;
      end
      tick;
      checks++;
      if (m1 !== 32'h00001357) begin
         $display("FAIL debug_nobypass_next: got %h expected 00001357", m1);
         errors++;
      end
   endtask

   task automatic test_back_to_back;
      scrub = 1'b1;
      tick;
      checks++;
      if (busy0 !== 1'b1) begin
         $display("FAIL b2b_start: got %b expected 1", busy0);
         errors++;
      end
      for (int j = 1; j <= 15; j++) tick;
      tick;
      checks++;
      if (busy0 !== 1'b0) begin
         $display("FAIL b2b_end: got %b expected 0", busy0);
         errors++;
      end
      tick;
      checks++;
      if (busy0 !== 1'b1) begin
         $display("FAIL b2b_restart: got %b expected 1", busy0);
         errors++;
      end
      scrub = 1'b0;
      clear = 1'b1;
      tick;
      clear = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0; errors = 0;
      clear = 1'b0; load = 1'b0; scrub = 1'b0;
      a_addr = 4'd0; b_addr = 4'd0; c_addr = 4'd0; c_data = 16'h0000;
      m_state = 4'd0;
      tick;
      test_reset;
      test_bypass;
      test_zero_reg;
      test_scrub;
      test_clear_mid;
      test_debug;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
